// File: rtl/req_pkg.sv
// Shared constants and types for the request capture stage that feeds the
// 16-input priority encoder.
package req_pkg;

  localparam int N_REQ    = 16;
  localparam int IDX_W    = 4;
  localparam int CNT_W    = 8;
  localparam int SYNC_DEF = 2;

  typedef logic [N_REQ-1:0] req_vec_t;
  typedef logic [IDX_W-1:0] req_idx_t;

endpackage

// File: rtl/req_sync_edge.sv
// One request line: multi-flop synchronizer plus a history flop,
// producing a single-cycle rise indication.
module req_sync_edge #(
  parameter int SYNC_STAGES = req_pkg::SYNC_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic req_in,
  output logic rise
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_prev;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync <= '0;
      r_prev <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], req_in};
      r_prev <= r_sync[SYNC_STAGES-1];
    end
  end

  assign rise = r_sync[SYNC_STAGES-1] & ~r_prev;

endmodule

// File: rtl/req_capture.sv
// Captures rising edges on N asynchronous request lines into a sticky pending
// vector, cleared one bit per index acknowledge, with a saturating miss counter.
module req_capture #(
  parameter  int N           = req_pkg::N_REQ,
  parameter  int SYNC_STAGES = req_pkg::SYNC_DEF,
  parameter  int CNT_W       = req_pkg::CNT_W,
  localparam int IDX_W       = $clog2(N)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N-1:0]     req_in,
  input  logic             enable,
  input  logic             ack_valid,
  input  logic [IDX_W-1:0] ack_idx,
  output logic [N-1:0]     pend_out,
  output logic             pend_any,
  output logic [CNT_W-1:0] miss_cnt
);

  logic [N-1:0]     w_rise;
  logic [N-1:0]     w_set;
  logic [N-1:0]     w_clr;
  logic [N-1:0]     w_miss;
  logic [N-1:0]     w_pend_nxt;
  logic [N-1:0]     r_pend;
  logic             r_pend_any;
  logic [CNT_W-1:0] r_miss_cnt;

  for (genvar g = 0; g < N; g++) begin : g_line
    req_sync_edge #(
      .SYNC_STAGES(SYNC_STAGES)
    ) u_sync_edge (
      .clk   (clk),
      .rst   (rst),
      .req_in(req_in[g]),
      .rise  (w_rise[g])
    );
  end

  // Out-of-range indices match no bit, so they clear nothing.
  always_comb begin
    w_clr = '0;
    for (int i = 0; i < N; i++) begin
      w_clr[i] = ack_valid && (32'(ack_idx) == i);
    end
  end

  // A new edge wins over a same-cycle ack, so it is never dropped.
  assign w_set      = {N{enable}} & w_rise;
  assign w_miss     = w_set & r_pend & ~w_clr;
  assign w_pend_nxt = w_set | (r_pend & ~w_clr);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pend     <= '0;
      r_pend_any <= 1'b0;
      r_miss_cnt <= '0;
    end else begin
      r_pend     <= w_pend_nxt;
      r_pend_any <= |w_pend_nxt;
      if ((|w_miss) && (r_miss_cnt != {CNT_W{1'b1}})) begin
        r_miss_cnt <= r_miss_cnt + 1'b1;
      end
    end
  end

  assign pend_out = r_pend;
  assign pend_any = r_pend_any;
  assign miss_cnt = r_miss_cnt;

endmodule

// File: doc/req_capture.md
# req_capture

Upstream capture stage for the 16-input priority encoder. Synchronizes 16 raw request lines into `clk`, detects rising edges, and holds each event in a sticky pending vector that drives the encoder input. When the consumer services a request, it clears that pending bit with an index acknowledge. A saturating counter records request edges that arrive while the same line is still pending.

## Interface
- `N`, 16, number of request lines; `ack_idx` width is `IDX_W = $clog2(N)`.
- `SYNC_STAGES`, 2, synchronizer depth per line; minimum 2.
- `CNT_W`, 8, width of the miss counter.

- `clk`  in  1  single clock; all state updates on its rising edge.
- `rst`  in  1  reset, synchronous, active-high; sampled on rising `clk`.
- `req_in`  in  N  raw request lines, asynchronous to `clk`; an event is a 0→1 transition.
- `enable`  in  1  1 = latch new edges; 0 = ignore new edges.
- `ack_valid`  in  1  clear request for one pending bit, single-cycle pulse.
- `ack_idx`  in  IDX_W  index of the pending bit to clear.
- `pend_out`  out  N  registered pending vector; feeds the priority encoder.
- `pend_any`  out  1  registered OR of the next `pend_out` value; aligned with `pend_out`.
- `miss_cnt`  out  CNT_W  saturating count of cycles with at least one lost edge.

## Operation
- **Per-line pipeline:** SYNC_STAGES flops, then one history flop `prev`.
  - `rise[i] = sync_last[i] & ~prev[i]`.
- **Pending update, per bit `i`, each cycle:**
  - `set[i] = enable & rise[i]`.
  - `clr[i] = ack_valid & (ack_idx == i)`.
  - `pend[i] <= set[i] | (pend[i] & ~clr[i])`.
  - Set wins over clear in the same cycle: a new event arriving while the old one is acked stays pending.
- **Ack rules:**
  - An ack to a bit that is not pending has no effect.
  - `ack_idx >= N` is ignored.
  - Exactly one bit is cleared per ack.
- **Miss detection:**
  - `miss[i] = enable & rise[i] & pend[i] & ~clr[i]`.
  - If any `miss[i]` is set, `miss_cnt` increments by 1 in that cycle, not once per bit.
  - `miss_cnt` saturates at 2^CNT_W−1 and clears only on `rst`.
- **`enable` = 0:**
  - Edges are consumed by the history flop and are lost, not deferred.
  - Pending bits are retained, acks are still honored, and no misses are counted.
- **Reset:**
  - Synchronizer, `prev`, `pend_out`, `pend_any` and `miss_cnt` all go to 0.
  - Reset asserted mid-operation discards all pending events and counts.
  - A line held high through reset release is treated as a fresh edge and produces one pending event.

## Timing
- **Edge latency:** `req_in[i]` is high at clock edge k; this is sampled into sync stage 1.
  - With SYNC_STAGES=2, `rise` is valid during the cycle after edge k+1.
  - `pend_out[i]` = 1 after edge k+2, i.e. SYNC_STAGES+1 edges.
- **Pulse width:** pulses shorter than one `clk` period may be missed. Inputs must be held for at least 2 periods to guarantee capture.
- **Ack latency:** `ack_valid` sampled at edge m → `pend_out` bit low after edge m (1 cycle).
- **Re-arm:** a line must return low for ≥2 cycles before its next rise is detected.
- **Encoder path:** the encoder is combinational on `pend_out`, so index → ack → clear completes in one cycle per request.
- No combinational path from any input to any output.

## Structure
- **Package `req_pkg`:**
  - Constants `N_REQ=16`, `IDX_W=4`, `CNT_W=8`.
  - Typedefs `req_vec_t` (logic [N_REQ-1:0]) and `req_idx_t`.
- **Sub-module `req_sync_edge`:** one line's synchronizer chain plus history flop, with output `rise`. Instantiate it N times in a generate loop.
- **Top level:** the pending register, ack decoder, miss OR-reduction and saturating counter stay in `req_capture`.

## Test plan
- **Reset state:** `rst`=1 for 2 cycles with `req_in`=0 → `pend_out`=0x0000, `pend_any`=0, `miss_cnt`=0.
- **Single edge + ack:** `req_in[5]` rises at edge k → `pend_out`=0x0020 after edge k+2. Then `ack_valid`=1, `ack_idx`=5 → `pend_out`=0x0000 the next cycle.
- **Multiple lines:** `req_in` 0x0000→0x8001 → `pend_out`=0x8001. Ack idx 15 → 0x0001; ack idx 3 → unchanged 0x0001.
- **Simultaneous set/clear:** bit 2 pending; the new rise on bit 2 reaches `rise` in the same cycle as ack idx 2 → `pend_out[2]` stays 1 and `miss_cnt` is unchanged.
- **Miss counting:** bits 0 and 1 pending; both lines toggle low then high together → `miss_cnt`=1. Repeat 300 times → `miss_cnt` saturates at 255.
- **Enable and reset:** `enable`=0 while `req_in[7]` rises → `pend_out`=0. Hold `req_in[9]`=1 through `rst` → `pend_out[9]`=1 three edges after reset release.
